// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types, default sizes and the round-robin pick helper for the job scheduler.
package cnn_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} sched_state_t;
  localparam int DEF_IMG_SIZE = 64;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_OUT_W = 32;
  localparam int MAX_REQ = 8;
  localparam int MAX_W = $clog2(MAX_REQ);
  // First set request at or after ptr, wrapping modulo n; one-hot result.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n = MAX_REQ);
    logic [MAX_W-1:0] k;
    rr_pick = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      k = MAX_W'((ptr + i) % n);
      if (i < n && req[k]) rr_pick = MAX_REQ'(1) << k;
    end
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot pick starting at ptr.
module rr_arbiter import cnn_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt
);
  assign gnt = NUM_REQ'(rr_pick(MAX_REQ'(req), int'(ptr), NUM_REQ));
endmodule

// File: rtl/cnn_job_scheduler.sv
// cnn_job_scheduler: shares one cnn_top core among NUM_REQ requesters,
// loading the winner's image, running the core and returning its result.
module cnn_job_scheduler import cnn_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IMG_SIZE = DEF_IMG_SIZE,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic [NUM_REQ-1:0]         pix_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  pix_data,
  output logic                       pix_ready,
  output logic [NUM_REQ-1:0]         res_valid,
  output logic                       res_timeout,
  output logic [OUT_W-1:0]           res_data,
  output logic                       cnn_enable,
  output logic [IMG_SIZE*DATA_W-1:0] cnn_img,
  input  logic [OUT_W-1:0]           cnn_value,
  input  logic                       cnn_done,
  output logic                       busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(IMG_SIZE + 1);
  localparam int AW = $clog2(IMG_SIZE);
  localparam int TW = $clog2(TIMEOUT);
  sched_state_t state, state_nx;
  logic [NUM_REQ-1:0] pick;
  logic [PW-1:0] rr_ptr, gidx;
  logic [WW-1:0] word_cnt;
  logic [TW-1:0] to_cnt;
  logic [IMG_SIZE-1:0][DATA_W-1:0] img;
  logic [NUM_REQ-1:0][DATA_W-1:0] pix_w;
  logic to_flag, held, accept, last, done_ok, tmo;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(req), .ptr(rr_ptr), .gnt(pick));
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gidx = PW'(i);
  end
  assign pix_w = pix_data;
  assign held = |(req & gnt);
  assign accept = state == LOAD && held && |(pix_valid & gnt);
  assign last = word_cnt == WW'(IMG_SIZE - 1);
  // A done left over from the previous job is masked on the first RUN cycle.
  assign done_ok = cnn_done && to_cnt != '0;
  assign tmo = to_cnt == TW'(TIMEOUT - 1);
  assign pix_ready = state == LOAD;
  assign cnn_enable = state == RUN;
  assign busy = state != IDLE;
  assign res_valid = (state == REPORT) ? gnt : '0;
  assign res_timeout = state == REPORT && to_flag;
  assign cnn_img = img;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = |req ? LOAD : IDLE;
      LOAD: state_nx = !held ? IDLE : (accept && last) ? RUN : LOAD;
      RUN: state_nx = !held ? IDLE : (done_ok || tmo) ? REPORT : RUN;
      REPORT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt <= '0;
      rr_ptr <= '0;
      word_cnt <= '0;
      to_cnt <= '0;
      to_flag <= 1'b0;
      res_data <= '0;
      img <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |req) begin
        gnt <= pick;
        word_cnt <= '0;
      end
      if (accept) begin
        img[word_cnt[AW-1:0]] <= pix_w[gidx];
        word_cnt <= word_cnt + 1'b1;
      end
      if (accept && last) to_cnt <= '0;
      if (state == RUN) to_cnt <= to_cnt + 1'b1;
      if (state == RUN && done_ok) begin
        res_data <= cnn_value;
        to_flag <= 1'b0;
      end else if (state == RUN && tmo) begin
        res_data <= '0;
        to_flag <= 1'b1;
      end
      // Leaving a job (completed or aborted) always advances past its owner.
      if (state != IDLE && state_nx == IDLE) begin
        gnt <= '0;
        rr_ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end
endmodule
